// File: rtl/register_file_if.sv
// Register file access bundle: one write port, two read ports.
// Master drives indices and write data; slave returns read data.
interface register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  regWrite;
    logic [ADDR_WIDTH-1:0] writeReg;
    logic [DATA_WIDTH-1:0] writeData;
    logic [ADDR_WIDTH-1:0] readReg1;
    logic [DATA_WIDTH-1:0] readData1;
    logic [ADDR_WIDTH-1:0] readReg2;
    logic [DATA_WIDTH-1:0] readData2;

    modport master (
        output regWrite,
        output writeReg,
        output writeData,
        output readReg1,
        output readReg2,
        input  readData1,
        input  readData2
    );

    modport slave (
        input  regWrite,
        input  writeReg,
        input  writeData,
        input  readReg1,
        input  readReg2,
        output readData1,
        output readData2
    );
endinterface

// File: rtl/register_file.sv
// MIPS general-purpose register file, 2 async read ports, 1 write port.
// Writes land on the falling edge so write-back data is readable the same cycle.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic            clk,
    input  logic            rst,
    register_file_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    // Next state: update the addressed register; index 0 is never written
    always_comb begin
        regs_d = regs_q;
        if (bus.regWrite && (bus.writeReg != '0)) begin
            regs_d[bus.writeReg] = bus.writeData;
        end
    end

    // Storage captures on the falling edge; reset clears everything at once
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational reads with register 0 forced to zero, no bypass
    always_comb begin
        bus.readData1 = '0;
        bus.readData2 = '0;
        if (bus.readReg1 != '0) begin
            bus.readData1 = regs_q[bus.readReg1];
        end
        if (bus.readReg2 != '0) begin
            bus.readData2 = regs_q[bus.readReg2];
        end
    end
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file against an array reference model.
// Inputs change after the rising edge; checks sample 1ns after edges.
module tb_register_file;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] model [32];

    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    task automatic do_write(input logic we, input logic [4:0] wa,
                            input logic [31:0] wd);
        @(posedge clk);
        #1;
        bus.regWrite  = we;
        bus.writeReg  = wa;
        bus.writeData = wd;
        @(negedge clk);
        #1;
        bus.regWrite = 1'b0;
        if (we && wa != 5'd0) model[wa] = wd;
    endtask

    task automatic test_reset();
        do_write(1'b1, 5'd1, 32'h1111_1111);
        do_write(1'b1, 5'd31, 32'h3131_3131);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        begin
            logic [4:0] idx [3];
            idx[0] = 5'd0; idx[1] = 5'd1; idx[2] = 5'd31;
            for (int k = 0; k < 3; k++) begin
                bus.readReg1 = idx[k];
                bus.readReg2 = idx[k];
                #0.5;
                checks++;
                if (bus.readData1 !== 32'h0 || bus.readData2 !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_clear idx=%0d got %h/%h want 0",
                             idx[k], bus.readData1, bus.readData2);
                end
            end
        end
        bus.regWrite  = 1'b1;
        bus.writeReg  = 5'd7;
        bus.writeData = 32'hFFFF_FFFF;
        bus.readReg1  = 5'd7;
        @(negedge clk);
        #1;
        checks++;
        if (bus.readData1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_blocks_write got %h want 0", bus.readData1);
        end
        bus.regWrite = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_write(1'b1, 5'd1, 32'h0000_000A);
        do_write(1'b1, 5'd2, 32'h0000_000B);
        bus.readReg1 = 5'd1;
        bus.readReg2 = 5'd2;
        #1;
        checks++;
        if (bus.readData1 !== 32'h0000_000A || bus.readData2 !== 32'h0000_000B) begin
            errors++;
            $display("FAIL basic_rw got %h/%h want 0000000a/0000000b",
                     bus.readData1, bus.readData2);
        end
    endtask

    task automatic test_write_disabled();
        do_write(1'b0, 5'd3, 32'h0000_000C);
        bus.readReg1 = 5'd3;
        bus.readReg2 = 5'd3;
        #1;
        checks++;
        if (bus.readData1 !== 32'h0 || bus.readData2 !== 32'h0) begin
            errors++;
            $display("FAIL write_disabled got %h/%h want 0",
                     bus.readData1, bus.readData2);
        end
    endtask

    task automatic test_reg_zero();
        do_write(1'b1, 5'd0, 32'h0000_000C);
        bus.readReg1 = 5'd0;
        bus.readReg2 = 5'd0;
        #1;
        checks++;
        if (bus.readData1 !== 32'h0 || bus.readData2 !== 32'h0) begin
            errors++;
            $display("FAIL reg_zero got %h/%h want 0",
                     bus.readData1, bus.readData2);
        end
    endtask

    task automatic test_edge_sensitivity();
        @(negedge clk);
        #1;
        bus.regWrite  = 1'b1;
        bus.writeReg  = 5'd5;
        bus.writeData = 32'hDEAD_BEEF;
        bus.readReg1  = 5'd5;
        bus.readReg2  = 5'd5;
        @(posedge clk);
        #1;
        checks++;
        if (bus.readData1 !== model[5] || bus.readData2 !== model[5]) begin
            errors++;
            $display("FAIL edge_rise_nowrite got %h/%h want %h",
                     bus.readData1, bus.readData2, model[5]);
        end
        @(negedge clk);
        #1;
        model[5] = 32'hDEAD_BEEF;
        bus.regWrite = 1'b0;
        checks++;
        if (bus.readData1 !== 32'hDEAD_BEEF || bus.readData2 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL edge_fall_write got %h/%h want deadbeef",
                     bus.readData1, bus.readData2);
        end
    endtask

    task automatic test_full_sweep();
        for (int i = 1; i < 32; i++) begin
            do_write(1'b1, 5'(i), 32'(i) * 32'h0101_0101);
        end
        for (int i = 0; i < 32; i++) begin
            logic [31:0] exp;
            exp = (i == 0) ? 32'h0 : 32'(i) * 32'h0101_0101;
            bus.readReg1 = 5'(i);
            bus.readReg2 = 5'(31 - i);
            #1;
            checks++;
            if (bus.readData1 !== exp) begin
                errors++;
                $display("FAIL sweep_port1 idx=%0d got %h want %h",
                         i, bus.readData1, exp);
            end
            checks++;
            if (bus.readData2 !== model[31 - i]) begin
                errors++;
                $display("FAIL sweep_port2 idx=%0d got %h want %h",
                         31 - i, bus.readData2, model[31 - i]);
            end
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        for (int i = 0; i < 32; i++) begin
            bus.readReg1 = 5'(i);
            bus.readReg2 = 5'(i);
            #0.1;
            checks++;
            if (bus.readData1 !== 32'h0 || bus.readData2 !== 32'h0) begin
                errors++;
                $display("FAIL sweep_reset idx=%0d got %h/%h want 0",
                         i, bus.readData1, bus.readData2);
            end
        end
        #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            logic        we;
            logic [4:0]  wa;
            logic [31:0] wd;
            logic [4:0]  r1;
            logic [4:0]  r2;
            we = 1'($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            r1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            @(posedge clk);
            #1;
            bus.regWrite  = we;
            bus.writeReg  = wa;
            bus.writeData = wd;
            bus.readReg1  = r1;
            bus.readReg2  = r2;
            #1;
            checks++;
            if (bus.readData1 !== model[r1] || bus.readData2 !== model[r2]) begin
                errors++;
                $display("FAIL rand_before n=%0d got %h/%h want %h/%h",
                         n, bus.readData1, bus.readData2, model[r1], model[r2]);
            end
            @(negedge clk);
            #1;
            if (we && wa != 5'd0) model[wa] = wd;
            bus.regWrite = 1'b0;
            checks++;
            if (bus.readData1 !== model[r1] || bus.readData2 !== model[r2]) begin
                errors++;
                $display("FAIL rand_after n=%0d got %h/%h want %h/%h",
                         n, bus.readData1, bus.readData2, model[r1], model[r2]);
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.regWrite  = 1'b0;
        bus.writeReg  = '0;
        bus.writeData = '0;
        bus.readReg1  = '0;
        bus.readReg2  = '0;
        model_clear();
        #12;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_write_disabled();
        test_reg_zero();
        test_edge_sensitivity();
        test_full_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
